// File: rtl/operand_bank.sv
// operand_bank: two-matrix operand store (A and B) with a random-access read
// port and a handshaked row/column streaming port feeding the MAC array.
module operand_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 4,
  parameter int ROW_AW     = $clog2(MAX_DIM),
  parameter int DIM_W      = $clog2(MAX_DIM) + 1,
  localparam int ROW_WIDTH = DATA_WIDTH * MAX_DIM
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic                 wr_mat_i,
  input  logic [ROW_AW-1:0]    wr_row_i,
  input  logic [ROW_WIDTH-1:0] wr_data_i,
  output logic                 wr_err_o,
  input  logic                 rd_en_i,
  input  logic                 rd_mat_i,
  input  logic [ROW_AW-1:0]    rd_row_i,
  output logic [ROW_WIDTH-1:0] rd_data_o,
  output logic                 rd_valid_o,
  input  logic                 start_i,
  input  logic                 mat_sel_i,
  input  logic                 transpose_i,
  input  logic [DIM_W-1:0]     dim_i,
  output logic                 busy_o,
  output logic [ROW_WIDTH-1:0] stream_data_o,
  output logic                 stream_valid_o,
  input  logic                 stream_ready_i,
  output logic                 stream_last_o
);

  typedef enum logic {IDLE, STREAM} state_e;

  logic [ROW_WIDTH-1:0] mem_q [2][MAX_DIM];

  state_e               state_q, state_d;
  logic [ROW_AW-1:0]    idx_q, idx_d;
  logic                 matSel_q, matSel_d;
  logic                 transpose_q, transpose_d;
  logic [DIM_W-1:0]     dim_q, dim_d;
  logic [ROW_WIDTH-1:0] streamData_q, streamData_d;
  logic [ROW_WIDTH-1:0] rdData_q;
  logic                 rdValid_q;
  logic                 wrErr_q;

  logic startOk;
  logic accept;
  logic lastIdx;
  logic wrBlocked;
  logic loadVec;

  assign startOk   = start_i && (dim_i != '0) && (dim_i <= DIM_W'(MAX_DIM));
  assign lastIdx   = (idx_q == ROW_AW'(dim_q - DIM_W'(1)));
  assign accept    = (state_q == STREAM) && stream_ready_i;
  assign wrBlocked = wr_en_i && (state_q == STREAM) && (wr_mat_i == matSel_q);

  // Operand storage: writes to the matrix currently being streamed are refused
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int m = 0; m < 2; m++) begin
        for (int r = 0; r < MAX_DIM; r++) begin
          mem_q[m][r] <= '0;
        end
      end
      wrErr_q <= 1'b0;
    end else begin
      if (wr_en_i && !wrBlocked) begin
        mem_q[wr_mat_i][wr_row_i] <= wr_data_i;
      end
      wrErr_q <= wrBlocked;
    end
  end

  // Random read port: one-cycle latency, data holds between reads, old data on same-row write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdValid_q <= rd_en_i;
      if (rd_en_i) begin
        rdData_q <= mem_q[rd_mat_i][rd_row_i];
      end
    end
  end

  // Stream FSM state register together with the latched stream parameters and vector
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      matSel_q     <= 1'b0;
      transpose_q  <= 1'b0;
      dim_q        <= '0;
      streamData_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      matSel_q     <= matSel_d;
      transpose_q  <= transpose_d;
      dim_q        <= dim_d;
      streamData_q <= streamData_d;
    end
  end

  // Next-state logic: accept a legal start in IDLE, advance the index on each handshake
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    matSel_d    = matSel_q;
    transpose_d = transpose_q;
    dim_d       = dim_q;
    loadVec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (startOk) begin
          state_d     = STREAM;
          idx_d       = '0;
          matSel_d    = mat_sel_i;
          transpose_d = transpose_i;
          dim_d       = dim_i;
          loadVec     = 1'b1;
        end
      end
      STREAM: begin
        if (accept) begin
          if (lastIdx) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            loadVec = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: build the next presented vector from storage, zero-masking elements beyond N
  always_comb begin
    streamData_d = streamData_q;
    if (loadVec) begin
      streamData_d = '0;
      for (int k = 0; k < MAX_DIM; k++) begin
        if (k < int'(dim_d)) begin
          if (transpose_d) begin
            streamData_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[matSel_d][k][idx_d*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            streamData_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[matSel_d][idx_d][k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end else if (state_d == IDLE) begin
      streamData_d = '0;
    end
  end

  assign busy_o         = (state_q == STREAM);
  assign stream_valid_o = (state_q == STREAM);
  assign stream_last_o  = (state_q == STREAM) && lastIdx;
  assign stream_data_o  = streamData_q;
  assign rd_data_o      = rdData_q;
  assign rd_valid_o     = rdValid_q;
  assign wr_err_o       = wrErr_q;

endmodule

// File: tb/tb_operand_bank.sv
// tb_operand_bank: scoreboard-driven bench for operand_bank with MAX_DIM=4, DATA_WIDTH=8.
module tb_operand_bank;
  localparam int DW   = 8;
  localparam int MD   = 4;
  localparam int RW   = DW * MD;
  localparam int AW   = 2;
  localparam int DIMW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, wr_mat, rd_en, rd_mat;
  logic [AW-1:0] wr_row, rd_row;
  logic [RW-1:0] wr_data, rd_data, stream_data;
  logic          wr_err, rd_valid;
  logic          start, mat_sel, transpose, busy, stream_valid, stream_ready, stream_last;
  logic [DIMW-1:0] dim;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [RW-1:0] data;
    logic          last;
  } vec_t;

  logic [RW-1:0] model [2][MD];
  vec_t          streamQ[$];
  logic [RW-1:0] readQ[$];

  // Free-running clock
  always #5 clk = ~clk;

  operand_bank #(.DATA_WIDTH(DW), .MAX_DIM(MD)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_en_i(wr_en), .wr_mat_i(wr_mat), .wr_row_i(wr_row), .wr_data_i(wr_data), .wr_err_o(wr_err),
    .rd_en_i(rd_en), .rd_mat_i(rd_mat), .rd_row_i(rd_row), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .start_i(start), .mat_sel_i(mat_sel), .transpose_i(transpose), .dim_i(dim), .busy_o(busy),
    .stream_data_o(stream_data), .stream_valid_o(stream_valid), .stream_ready_i(stream_ready),
    .stream_last_o(stream_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] expVec(input logic m, input logic tr, input int n, input int idx);
    logic [RW-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) begin
      if (tr) v[k*DW +: DW] = model[m][k][idx*DW +: DW];
      else    v[k*DW +: DW] = model[m][idx][k*DW +: DW];
    end
    return v;
  endfunction

  // Issue a write and verify whether the error pulse follows
  task automatic doWrite(input logic m, input int row, input logic [RW-1:0] d, input logic blocked);
    wr_en = 1'b1; wr_mat = m; wr_row = AW'(row); wr_data = d;
    tick();
    wr_en = 1'b0;
    checks++;
    if (wr_err !== blocked) begin
      errors++;
      $display("[TB] FAIL wr_err m=%0d row=%0d got %b want %b", m, row, wr_err, blocked);
    end
    if (!blocked) model[m][row] = d;
  endtask

  // Issue a read; the expected row is pushed now and popped when rd_valid appears
  task automatic doRead(input logic m, input int row);
    logic [RW-1:0] e;
    readQ.push_back(model[m][row]);
    rd_en = 1'b1; rd_mat = m; rd_row = AW'(row);
    tick();
    rd_en = 1'b0;
    e = readQ.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== e) begin
      errors++;
      $display("[TB] FAIL read m=%0d row=%0d got valid=%b data=%h want valid=1 data=%h", m, row, rd_valid, rd_data, e);
    end
  endtask

  // Pulse start and queue the vectors the stream should produce
  task automatic startStream(input logic m, input logic tr, input int n);
    for (int i = 0; i < n; i++) streamQ.push_back('{data: expVec(m, tr, n, i), last: (i == n - 1)});
    start = 1'b1; mat_sel = m; transpose = tr; dim = DIMW'(n);
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || stream_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stream_start got busy=%b valid=%b want busy=1 valid=1", busy, stream_valid);
    end
  endtask

  // Consume queued vectors under a ready pattern, checking content, last flag and stall stability
  task automatic drainStream(input logic [15:0] pattern, input int plen, input int expAccepts);
    int   cyc, accepts;
    logic held;
    vec_t heldV, e;
    cyc = 0; accepts = 0; held = 1'b0; heldV = '0;
    while (streamQ.size() > 0 && cyc < 100) begin
      stream_ready = (cyc < plen) ? pattern[cyc] : 1'b1;
      if (held) begin
        checks++;
        if (stream_data !== heldV.data || stream_last !== heldV.last) begin
          errors++;
          $display("[TB] FAIL stall_stable got %h/%b want %h/%b", stream_data, stream_last, heldV.data, heldV.last);
        end
      end
      if (stream_valid !== 1'b1) begin
        checks++; errors++;
        $display("[TB] FAIL stream_valid got %b want 1 (cycle %0d)", stream_valid, cyc);
        held = 1'b0;
      end else if (stream_ready) begin
        e = streamQ.pop_front();
        accepts++;
        checks++;
        if (stream_data !== e.data || stream_last !== e.last) begin
          errors++;
          $display("[TB] FAIL stream_vec got %h last=%b want %h last=%b", stream_data, stream_last, e.data, e.last);
        end
        held = 1'b0;
      end else begin
        held = 1'b1;
        heldV = '{data: stream_data, last: stream_last};
      end
      tick();
      cyc++;
    end
    stream_ready = 1'b0;
    if (streamQ.size() > 0) begin
      checks++; errors++;
      $display("[TB] FAIL stream_timeout got %0d vectors left want 0", streamQ.size());
      streamQ.delete();
    end
    checks++;
    if (accepts != expAccepts || busy !== 1'b0 || stream_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_end got accepts=%0d busy=%b valid=%b want %0d/0/0", accepts, busy, stream_valid, expAccepts);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({rd_valid, wr_err, busy, stream_valid, stream_last} !== 5'b0 || rd_data !== '0 || stream_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got rv=%b we=%b b=%b sv=%b sl=%b rd=%h sd=%h want all 0",
               rd_valid, wr_err, busy, stream_valid, stream_last, rd_data, stream_data);
    end
    rst_n = 1'b1;
    tick();
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < MD; r++) doRead(m[0], r);
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_valid_pulse got %b want 0", rd_valid);
    end
  endtask

  task automatic test_row_stream();
    doWrite(1'b0, 0, 32'h03020100, 1'b0);
    doWrite(1'b0, 1, 32'h13121110, 1'b0);
    doWrite(1'b0, 2, 32'h23222120, 1'b0);
    doWrite(1'b0, 3, 32'h33323130, 1'b0);
    startStream(1'b0, 1'b0, 4);
    drainStream(16'hFFFF, 16, 4);
  endtask

  task automatic test_transpose();
    startStream(1'b0, 1'b1, 3);
    drainStream(16'hFFFF, 16, 3);
  endtask

  task automatic test_backpressure();
    doWrite(1'b1, 0, 32'h43424140, 1'b0);
    doWrite(1'b1, 1, 32'h53525150, 1'b0);
    startStream(1'b1, 1'b0, 2);
    drainStream(16'b1001, 4, 2);
  endtask

  task automatic test_back_to_back();
    startStream(1'b1, 1'b1, 4);
    drainStream(16'hFFFF, 16, 4);
    startStream(1'b0, 1'b0, 1);
    drainStream(16'hFFFF, 16, 1);
  endtask

  task automatic test_write_block();
    startStream(1'b0, 1'b0, 4);
    doWrite(1'b0, 1, 32'hDEADBEEF, 1'b1);
    doWrite(1'b1, 1, 32'hCAFEF00D, 1'b0);
    doRead(1'b1, 1);
    drainStream(16'hFFFF, 16, 4);
    doRead(1'b0, 1);
    readQ.push_back(model[1][2]);
    rd_en = 1'b1; rd_mat = 1'b1; rd_row = 2'd2;
    wr_en = 1'b1; wr_mat = 1'b1; wr_row = 2'd2; wr_data = 32'h77665544;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    model[1][2] = 32'h77665544;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== readQ[0]) begin
      errors++;
      $display("[TB] FAIL read_old_data got %h want %h", rd_data, readQ[0]);
    end
    void'(readQ.pop_front());
    doRead(1'b1, 2);
  endtask

  task automatic test_ignored_starts();
    start = 1'b1; mat_sel = 1'b0; transpose = 1'b0; dim = '0;
    tick();
    dim = 3'd5;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || stream_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_dim_start got busy=%b valid=%b want 0/0", busy, stream_valid);
    end
    startStream(1'b0, 1'b0, 4);
    start = 1'b1; mat_sel = 1'b1; transpose = 1'b1; dim = 3'd2;
    tick();
    start = 1'b0;
    drainStream(16'hFFFF, 16, 4);
    startStream(1'b1, 1'b1, 4);
    tick();
    rst_n = 1'b0;
    #1;
    streamQ.delete();
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < MD; r++) model[m][r] = '0;
    checks++;
    if ({rd_valid, wr_err, busy, stream_valid, stream_last} !== 5'b0 || rd_data !== '0 || stream_data !== '0) begin
      errors++;
      $display("[TB] FAIL midstream_reset got b=%b sv=%b sl=%b sd=%h rd=%h want all 0", busy, stream_valid, stream_last, stream_data, rd_data);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || stream_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_reset_idle got busy=%b valid=%b want 0/0", busy, stream_valid);
      end
    end
    doRead(1'b0, 1);
  endtask

  // Scenario sequence
  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_mat = 1'b0; wr_row = '0; wr_data = '0;
    rd_en = 1'b0; rd_mat = 1'b0; rd_row = '0;
    start = 1'b0; mat_sel = 1'b0; transpose = 1'b0; dim = '0; stream_ready = 1'b0;
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < MD; r++) model[m][r] = '0;
    test_reset();
    test_row_stream();
    test_transpose();
    test_backpressure();
    test_back_to_back();
    test_write_block();
    test_ignored_starts();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
